// File: rtl/spi_pkg.sv
// Shared types and constants for the single-byte full-duplex SPI exchange engine.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_e;

  localparam int SPI_BITS       = 8;
  localparam int SPI_HALF_EDGES = 16;
  localparam int SPI_HALF_W     = $clog2(SPI_HALF_EDGES);

  // Width of a down-counter that must hold div-1; never narrower than one bit.
  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: idle low, toggles every CLK_DIV cycles while enabled, with
// single-cycle strobes marking the mclk edge at which SCLK rises or falls.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic                  i_en,
  output logic                  o_sclk,
  output logic                  o_rise_stb,
  output logic                  o_fall_stb,
  output logic [SPI_HALF_W-1:0] o_half_cnt
);

  localparam int            DW       = div_width(CLK_DIV);
  localparam logic [DW-1:0] CNT_LOAD = DW'(CLK_DIV - 1);

  logic [DW-1:0]         r_div;
  logic                  r_sclk;
  logic [SPI_HALF_W-1:0] r_half;
  logic                  w_tc;

  assign w_tc       = i_en && (r_div == '0);
  assign o_rise_stb = w_tc && !r_sclk;
  assign o_fall_stb = w_tc && r_sclk;
  assign o_sclk     = r_sclk;
  assign o_half_cnt = r_half;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_div  <= CNT_LOAD;
      r_sclk <= 1'b0;
      r_half <= '0;
    end else if (!i_en) begin
      r_div  <= CNT_LOAD;
      r_sclk <= 1'b0;
      r_half <= '0;
    end else if (w_tc) begin
      r_div  <= CNT_LOAD;
      r_sclk <= ~r_sclk;
      r_half <= r_half + 1'b1;
    end else begin
      r_div  <= r_div - DW'(1);
    end
  end

endmodule

// File: rtl/spi_duplex_core.sv
// Back-to-back SPI master and slave (mode 0, MSB first) exchanging one byte
// per start; wire-level signals are exported for external monitors.
module spi_duplex_core
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                mclk,
  input  logic                reset,
  input  logic                load_master,
  input  logic                load_slave,
  input  logic                read_master,
  input  logic                read_slave,
  input  logic                start,
  input  logic [SPI_BITS-1:0] data_in_master,
  input  logic [SPI_BITS-1:0] data_in_slave,
  output logic [SPI_BITS-1:0] data_out_master,
  output logic [SPI_BITS-1:0] data_out_slave,
  output logic                busy,
  output logic                done,
  output logic                sclk,
  output logic                mosi,
  output logic                miso,
  output logic                ss_n
);

  // state | meaning
  // IDLE  | strobes honoured; a sampled start arms r_pend for one cycle
  // SETUP | ss_n low, bit 7 on both lines, CLK_DIV cycles
  // SHIFT | 16 SCLK half-periods; sample on rise, shift on fall
  // HOLD  | ss_n still low, SCLK low, CLK_DIV cycles
  // DONE  | one-cycle done pulse, strobes honoured, start ignored

  localparam int                    DW        = div_width(CLK_DIV);
  localparam logic [DW-1:0]         CNT_LOAD  = DW'(CLK_DIV - 1);
  localparam logic [SPI_HALF_W-1:0] LAST_HALF = SPI_HALF_W'(SPI_HALF_EDGES - 1);

  spi_state_e          r_state;
  logic [DW-1:0]       r_cnt;
  logic                r_pend;
  logic [SPI_BITS-1:0] r_master_sr;
  logic [SPI_BITS-1:0] r_slave_sr;
  logic                r_miso_q;
  logic                r_mosi_q;
  logic [SPI_BITS-1:0] r_dout_m;
  logic [SPI_BITS-1:0] r_dout_s;
  logic                r_busy;
  logic                r_done;
  logic                r_ss_n;

  logic                  w_sclk_en;
  logic                  w_sclk;
  logic                  w_rise;
  logic                  w_fall;
  logic [SPI_HALF_W-1:0] w_half;
  logic                  w_mosi;
  logic                  w_miso;

  assign w_sclk_en = (r_state == SHIFT);
  assign w_mosi    = r_master_sr[SPI_BITS-1];
  assign w_miso    = r_slave_sr[SPI_BITS-1];

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .mclk       (mclk),
    .reset      (reset),
    .i_en       (w_sclk_en),
    .o_sclk     (w_sclk),
    .o_rise_stb (w_rise),
    .o_fall_stb (w_fall),
    .o_half_cnt (w_half)
  );

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= CNT_LOAD;
      r_pend      <= 1'b0;
      r_master_sr <= '0;
      r_slave_sr  <= '0;
      r_miso_q    <= 1'b0;
      r_mosi_q    <= 1'b0;
      r_dout_m    <= '0;
      r_dout_s    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ss_n      <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (r_pend) begin
            r_pend  <= 1'b0;
            r_state <= SETUP;
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
            r_ss_n  <= 1'b0;
          end else begin
            // reads see the pre-load register value through NBA ordering
            if (read_master) r_dout_m    <= r_master_sr;
            if (read_slave)  r_dout_s    <= r_slave_sr;
            if (load_master) r_master_sr <= data_in_master;
            if (load_slave)  r_slave_sr  <= data_in_slave;
            if (r_state == DONE)
              r_state <= IDLE;
            else if (start)
              r_pend <= 1'b1;
          end
        end
        SETUP: begin
          if (r_cnt == '0)
            r_state <= SHIFT;
          else
            r_cnt <= r_cnt - DW'(1);
        end
        SHIFT: begin
          if (w_rise) begin
            r_miso_q <= w_miso;
            r_mosi_q <= w_mosi;
          end
          if (w_fall) begin
            r_master_sr <= {r_master_sr[SPI_BITS-2:0], r_miso_q};
            r_slave_sr  <= {r_slave_sr[SPI_BITS-2:0], r_mosi_q};
            if (w_half == LAST_HALF) begin
              r_state <= HOLD;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        HOLD: begin
          if (r_cnt == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_ss_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - DW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out_master = r_dout_m;
  assign data_out_slave  = r_dout_s;
  assign busy            = r_busy;
  assign done            = r_done;
  assign sclk            = w_sclk;
  assign mosi            = w_mosi;
  assign miso            = w_miso;
  assign ss_n            = r_ss_n;

endmodule

// File: tb/tb_spi_duplex_core.sv
// Scoreboard bench for spi_duplex_core: instance 0 at CLK_DIV=2, instance 1 at CLK_DIV=1.
module tb_spi_duplex_core;

  logic       mclk = 1'b0;
  logic       reset = 1'b0;
  logic       load_m[2], load_s[2], rd_m[2], rd_s[2], start[2];
  logic [7:0] din_m[2], din_s[2];
  logic [7:0] dout_m[2], dout_s[2];
  logic       busy[2], done[2], sclk[2], mosi[2], miso[2], ss_n[2];

  int n_vec = 0;
  int n_err = 0;

  int          q_lat[2][$];
  logic [7:0]  q_mosi[2][$];
  logic [15:0] q_rd[2][$];

  logic       st_q[2];
  logic       rd_q[2];
  int         since[2];
  logic [7:0] macc[2];

  always #5 mclk = ~mclk;

  spi_duplex_core #(.CLK_DIV(2)) u_d2 (
    .mclk(mclk), .reset(reset),
    .load_master(load_m[0]), .load_slave(load_s[0]),
    .read_master(rd_m[0]), .read_slave(rd_s[0]), .start(start[0]),
    .data_in_master(din_m[0]), .data_in_slave(din_s[0]),
    .data_out_master(dout_m[0]), .data_out_slave(dout_s[0]),
    .busy(busy[0]), .done(done[0]), .sclk(sclk[0]),
    .mosi(mosi[0]), .miso(miso[0]), .ss_n(ss_n[0])
  );

  spi_duplex_core #(.CLK_DIV(1)) u_d1 (
    .mclk(mclk), .reset(reset),
    .load_master(load_m[1]), .load_slave(load_s[1]),
    .read_master(rd_m[1]), .read_slave(rd_s[1]), .start(start[1]),
    .data_in_master(din_m[1]), .data_in_slave(din_s[1]),
    .data_out_master(dout_m[1]), .data_out_slave(dout_s[1]),
    .busy(busy[1]), .done(done[1]), .sclk(sclk[1]),
    .mosi(mosi[1]), .miso(miso[1]), .ss_n(ss_n[1])
  );

  // interface monitor: what the DUT sampled at each mclk edge
  always @(posedge mclk) begin
    for (int g = 0; g < 2; g++) begin
      st_q[g] <= start[g];
      rd_q[g] <= rd_m[g] | rd_s[g];
    end
  end

  always @(posedge sclk[0]) macc[0] <= {macc[0][6:0], mosi[0]};
  always @(posedge sclk[1]) macc[1] <= {macc[1][6:0], mosi[1]};

  // scoreboard checker, sampling mid-cycle
  always @(negedge mclk) begin
    for (int g = 0; g < 2; g++) begin
      if (st_q[g] === 1'b1 && busy[g] === 1'b0 && done[g] === 1'b0)
        since[g] = 0;
      else
        since[g] = since[g] + 1;

      if (done[g] === 1'b1) begin
        n_vec++;
        if (q_lat[g].size() == 0 || q_mosi[g].size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done inst%0d actual done=1 required no done", g);
        end else begin
          int         exp_lat;
          logic [7:0] exp_mosi;
          exp_lat  = q_lat[g].pop_front();
          exp_mosi = q_mosi[g].pop_front();
          if (since[g] != exp_lat) begin
            n_err++;
            $display("FAIL done_latency inst%0d actual %0d required %0d", g, since[g], exp_lat);
          end
          n_vec++;
          if (macc[g] !== exp_mosi) begin
            n_err++;
            $display("FAIL mosi_bits inst%0d actual %02h required %02h", g, macc[g], exp_mosi);
          end
        end
      end

      if (rd_q[g] === 1'b1) begin
        n_vec++;
        if (q_rd[g].size() == 0) begin
          n_err++;
          $display("FAIL unexpected_read inst%0d actual read strobe required none", g);
        end else begin
          logic [15:0] exp_rd;
          exp_rd = q_rd[g].pop_front();
          if ({dout_m[g], dout_s[g]} !== exp_rd) begin
            n_err++;
            $display("FAIL read_bytes inst%0d actual m=%02h s=%02h required m=%02h s=%02h",
                     g, dout_m[g], dout_s[g], exp_rd[15:8], exp_rd[7:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string name, input int g, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d actual %0h required %0h", name, g, act, exp);
    end
  endtask

  // one cycle of strobes on instance g
  task automatic strobe(input int g, input logic lm, input logic [7:0] vm,
                        input logic ls, input logic [7:0] vs,
                        input logic rm, input logic rs, input logic st);
    load_m[g] = lm; din_m[g] = vm;
    load_s[g] = ls; din_s[g] = vs;
    rd_m[g] = rm; rd_s[g] = rs; start[g] = st;
    tick();
    load_m[g] = 1'b0; load_s[g] = 1'b0;
    rd_m[g] = 1'b0; rd_s[g] = 1'b0; start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    bit seen = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (done[g] === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout inst%0d actual no done required done within 100 cycles", g);
    end
  endtask

  task automatic read_both(input int g, input logic [7:0] em, input logic [7:0] es);
    q_rd[g].push_back({em, es});
    strobe(g, 0, 8'h00, 0, 8'h00, 1, 1, 0);
  endtask

  task automatic check_reset_vals(input int g, input string tag);
    chk({tag, "_dout_m"}, g, 16'(dout_m[g]), 16'h00);
    chk({tag, "_dout_s"}, g, 16'(dout_s[g]), 16'h00);
    chk({tag, "_busy"},   g, 16'(busy[g]),   16'h0);
    chk({tag, "_done"},   g, 16'(done[g]),   16'h0);
    chk({tag, "_sclk"},   g, 16'(sclk[g]),   16'h0);
    chk({tag, "_ss_n"},   g, 16'(ss_n[g]),   16'h1);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      load_m[g] = 0; load_s[g] = 0; rd_m[g] = 0; rd_s[g] = 0; start[g] = 0;
      din_m[g] = 8'h00; din_s[g] = 8'h00;
      st_q[g] = 0; rd_q[g] = 0; since[g] = 0; macc[g] = 8'h00;
    end
    reset = 1'b0;
    repeat (3) tick();
    check_reset_vals(0, "rst");
    check_reset_vals(1, "rst");
    reset = 1'b1;
    tick();

    // basic exchange
    strobe(0, 1, 8'hA5, 1, 8'h3C, 0, 0, 0);
    q_lat[0].push_back(37); q_mosi[0].push_back(8'hA5);
    strobe(0, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    wait_done(0);
    read_both(0, 8'h3C, 8'hA5);

    // back-to-back without reload
    q_lat[0].push_back(37); q_mosi[0].push_back(8'h3C);
    strobe(0, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    wait_done(0);
    read_both(0, 8'hA5, 8'h3C);

    // strobes while busy: load, read and a second start mid-SHIFT
    q_lat[0].push_back(37); q_mosi[0].push_back(8'hA5);
    strobe(0, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    repeat (14) tick();
    chk("mid_shift_busy", 0, 16'(busy[0]), 16'h1);
    chk("mid_shift_ss_n", 0, 16'(ss_n[0]), 16'h0);
    q_rd[0].push_back({8'hA5, 8'h3C});
    strobe(0, 1, 8'hFF, 0, 8'h00, 0, 1, 1);
    wait_done(0);
    read_both(0, 8'h3C, 8'hA5);

    // same-cycle load and start
    strobe(0, 0, 8'h00, 1, 8'h00, 0, 0, 0);
    q_lat[0].push_back(37); q_mosi[0].push_back(8'h81);
    strobe(0, 1, 8'h81, 0, 8'h00, 0, 0, 1);
    wait_done(0);
    read_both(0, 8'h00, 8'h81);

    // reset mid-transfer: no done, immediate return to reset values
    strobe(0, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    repeat (12) tick();
    chk("pre_abort_sclk_en", 0, 16'(ss_n[0]), 16'h0);
    reset = 1'b0;
    #1;
    check_reset_vals(0, "abort");
    repeat (2) tick();
    reset = 1'b1;
    tick();
    read_both(0, 8'h00, 8'h00);
    strobe(0, 1, 8'h96, 1, 8'h69, 0, 0, 0);
    q_lat[0].push_back(37); q_mosi[0].push_back(8'h96);
    strobe(0, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    wait_done(0);
    read_both(0, 8'h69, 8'h96);

    // CLK_DIV=1
    strobe(1, 1, 8'hF0, 1, 8'h0F, 0, 0, 0);
    q_lat[1].push_back(19); q_mosi[1].push_back(8'hF0);
    strobe(1, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    wait_done(1);
    read_both(1, 8'h0F, 8'hF0);

    repeat (5) tick();
    for (int g = 0; g < 2; g++) begin
      chk("lat_queue_drained", g, 16'(q_lat[g].size()), 16'h0);
      chk("rd_queue_drained",  g, 16'(q_rd[g].size()),  16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog actual time limit reached required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
